// File: rtl/lbist_misr_pkg.sv
// Shared types and constants for the LBIST signature register and its run controller.
// The optional X-masking feature is enabled with the macro LBIST_MISR_XMASK_EN.
package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2
    } lbist_state_e;

    // Default Galois feedback masks and seeds for the supported signature widths
    localparam logic [15:0] LBIST_POLY_W16 = 16'hB400;
    localparam logic [15:0] LBIST_SEED_W16 = 16'h0000;
    localparam logic [31:0] LBIST_POLY_W32 = 32'h80200003;
    localparam logic [31:0] LBIST_SEED_W32 = 32'h00000000;

endpackage

// File: rtl/lbist_misr_core.sv
// Signature register with Galois-style MISR next-state logic.
// A load takes priority over compaction; reset returns the register to SEED.
module misr_core #(
    parameter int unsigned  W    = 16,
    parameter logic [W-1:0] POLY = W'(16'hB400),
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o,
    output logic [W-1:0] sig_next_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic [W-1:0] compacted;

    // Shift right, fold the outgoing bit back through the tap mask, then absorb the data word
    assign compacted = (sig_q >> 1) ^ ({W{sig_q[0]}} & POLY) ^ data_i;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = load_val_i;
        end else if (en_i) begin
            sig_d = compacted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = compacted;

endmodule

// File: rtl/lbist_misr.sv
// LBIST run controller: compacts N_PATTERNS valid response words and compares against golden.
// Define LBIST_MISR_XMASK_EN to add the xmask input that blocks unknown bits from the signature.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int unsigned  W          = 16,
    parameter logic [W-1:0] POLY       = W'(LBIST_POLY_W16),
    parameter logic [W-1:0] SEED       = '0,
    parameter int unsigned  N_PATTERNS = 1000,
    localparam int unsigned CW         = $clog2(N_PATTERNS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          data_valid,
    input  logic [W-1:0]  data_in,
`ifdef LBIST_MISR_XMASK_EN
    input  logic [W-1:0]  xmask,
`endif
    input  logic [W-1:0]  golden,
    output logic [W-1:0]  signature,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N_PATTERNS - 1);

    lbist_state_e  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          pass_q, pass_d;
    logic          load;
    logic          en;
    logic [W-1:0]  eff_data;
    logic [W-1:0]  sig_next;

`ifdef LBIST_MISR_XMASK_EN
    assign eff_data = data_in & ~xmask;
`else
    assign eff_data = data_in;
`endif

    misr_core #(
        .W    (W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (SEED),
        .en_i       (en),
        .data_i     (eff_data),
        .sig_o      (signature),
        .sig_next_o (sig_next)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pass_d  = pass_q;
        load    = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_COMPACT;
                    count_d = '0;
                    pass_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            ST_COMPACT: begin
                if (data_valid) begin
                    en      = 1'b1;
                    count_d = count_q + CW'(1);
                    // Compare the value the register takes this edge, so pass lines up with done
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_next == golden);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_COMPACT);
    assign done  = (state_q == ST_DONE);
    assign pass  = pass_q;

endmodule
